mod_mem_arbiter: RTL and testbench

- Shares the single downstream memory/system-bus port between the L1 instruction cache and the L1 data cache.
- Sits between the two caches' CacheArbiterBus-side signals and the memory interface.
- Serialises transactions with exactly one outstanding at a time, and routes each response back to the requester that issued it.
- Uses round-robin arbitration when both requesters are pending.

---
 rtl/mod_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mod_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mem_arbiter.sv
// Shares one memory port between icache and dcache with round-robin grant and one transaction in flight.
// Request/response outputs are registered; m_respack is combinational from m_respcyc while waiting.
module mod_mem_arbiter #(
   parameter int ADDRWIDTH = 64,
   parameter int DATAWIDTH = 512,
   parameter int TAGWIDTH  = 13
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic [ADDRWIDTH-1:0] i_req,
   input  logic [TAGWIDTH-1:0]  i_reqtag,
   input  logic [DATAWIDTH-1:0] i_reqdata,
   input  logic                 i_reqcyc,
   output logic                 i_reqack,
   output logic [DATAWIDTH-1:0] i_resp,
   output logic [TAGWIDTH-1:0]  i_resptag,
   output logic                 i_respcyc,
   input  logic                 i_respack,

   input  logic [ADDRWIDTH-1:0] d_req,
   input  logic [TAGWIDTH-1:0]  d_reqtag,
   input  logic [DATAWIDTH-1:0] d_reqdata,
   input  logic                 d_reqcyc,
   output logic                 d_reqack,
   output logic [DATAWIDTH-1:0] d_resp,
   output logic [TAGWIDTH-1:0]  d_resptag,
   output logic                 d_respcyc,
   input  logic                 d_respack,

   output logic [ADDRWIDTH-1:0] m_req,
   output logic [TAGWIDTH-1:0]  m_reqtag,
   output logic [DATAWIDTH-1:0] m_reqdata,
   output logic                 m_reqcyc,
   input  logic                 m_reqack,
   input  logic [DATAWIDTH-1:0] m_resp,
   input  logic [TAGWIDTH-1:0]  m_resptag,
   input  logic                 m_respcyc,
   output logic                 m_respack
);

   typedef enum logic [1:0] {IDLE, FWD, WAIT, DELIVER} state_t;

   localparam logic ICACHE = 1'b0;
   localparam logic DCACHE = 1'b1;

   state_t state, state_nxt;
   logic   owner;
   logic   last_grant;
   logic   grant;
   logic   grant_sel;
   logic   owner_respack;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant         = 1'b0;
      grant_sel     = ICACHE;
      m_respack     = 1'b0;
      owner_respack = (owner == DCACHE) ? d_respack : i_respack;
      case (state)
         IDLE: begin
            if (i_reqcyc || d_reqcyc) begin
               grant = 1'b1;
               // On a tie the side that did not win last time goes first.
               grant_sel = (d_reqcyc && (!i_reqcyc || last_grant == ICACHE)) ? DCACHE : ICACHE;
               state_nxt = FWD;
            end
         end
         FWD: begin
            if (m_reqack) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            m_respack = m_respcyc;
            if (m_respcyc) begin
               state_nxt = DELIVER;
            end
         end
         DELIVER: begin
            if (owner_respack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         i_reqack   <= 1'b0;
         d_reqack   <= 1'b0;
         m_reqcyc   <= 1'b0;
         m_req      <= '0;
         m_reqtag   <= '0;
         m_reqdata  <= '0;
         owner      <= ICACHE;
         last_grant <= ICACHE;
      end else begin
         i_reqack <= grant && (grant_sel == ICACHE);
         d_reqack <= grant && (grant_sel == DCACHE);
         if (grant) begin
            m_reqcyc  <= 1'b1;
            owner     <= grant_sel;
            m_req     <= (grant_sel == DCACHE) ? d_req     : i_req;
            m_reqtag  <= (grant_sel == DCACHE) ? d_reqtag  : i_reqtag;
            m_reqdata <= (grant_sel == DCACHE) ? d_reqdata : i_reqdata;
         end else if (state == FWD && m_reqack) begin
            m_reqcyc <= 1'b0;
         end
         if (state == DELIVER && owner_respack) begin
            last_grant <= owner;
         end
      end
   end

   // Only the owner's response registers ever load; the other side keeps its values.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_resp    <= '0;
         i_resptag <= '0;
         i_respcyc <= 1'b0;
         d_resp    <= '0;
         d_resptag <= '0;
         d_respcyc <= 1'b0;
      end else begin
         if (state == WAIT && m_respcyc) begin
            if (owner == DCACHE) begin
               d_resp    <= m_resp;
               d_resptag <= m_resptag;
               d_respcyc <= 1'b1;
            end else begin
               i_resp    <= m_resp;
               i_resptag <= m_resptag;
               i_respcyc <= 1'b1;
            end
         end else if (state == DELIVER && owner_respack) begin
            i_respcyc <= 1'b0;
            d_respcyc <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Directed bench for mod_mem_arbiter: inputs change and outputs are checked on the falling edge.
module tb_mod_mem_arbiter;
   localparam int AW = 64;
   localparam int DW = 512;
   localparam int TW = 13;

   logic          clk;
   logic          reset;
   logic [AW-1:0] i_req, d_req, m_req;
   logic [TW-1:0] i_reqtag, d_reqtag, m_reqtag;
   logic [DW-1:0] i_reqdata, d_reqdata, m_reqdata;
   logic          i_reqcyc, d_reqcyc, m_reqcyc;
   logic          i_reqack, d_reqack, m_reqack;
   logic [DW-1:0] i_resp, d_resp, m_resp;
   logic [TW-1:0] i_resptag, d_resptag, m_resptag;
   logic          i_respcyc, d_respcyc, m_respcyc;
   logic          i_respack, d_respack, m_respack;

   int vectors;
   int miscompares;

   mod_mem_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TAGWIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_reqtag(i_reqtag), .i_reqdata(i_reqdata), .i_reqcyc(i_reqcyc),
      .i_reqack(i_reqack), .i_resp(i_resp), .i_resptag(i_resptag), .i_respcyc(i_respcyc),
      .i_respack(i_respack),
      .d_req(d_req), .d_reqtag(d_reqtag), .d_reqdata(d_reqdata), .d_reqcyc(d_reqcyc),
      .d_reqack(d_reqack), .d_resp(d_resp), .d_resptag(d_resptag), .d_respcyc(d_respcyc),
      .d_respack(d_respack),
      .m_req(m_req), .m_reqtag(m_reqtag), .m_reqdata(m_reqdata), .m_reqcyc(m_reqcyc),
      .m_reqack(m_reqack), .m_resp(m_resp), .m_resptag(m_resptag), .m_respcyc(m_respcyc),
      .m_respack(m_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic apply_reset();
      reset = 1'b1;
      i_reqcyc = 1'b0; d_reqcyc = 1'b0; i_respack = 1'b0; d_respack = 1'b0;
      m_reqack = 1'b0; m_respcyc = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // Memory side: ack now, respond next cycle, then the named requester consumes it.
   task automatic finish_txn(input logic to_d);
      m_reqack = 1'b1;
      @(negedge clk);
      m_reqack = 1'b0;
      m_resptag = 13'h0abc; m_resp = {16{32'h1234_5678}}; m_respcyc = 1'b1;
      @(negedge clk);
      m_respcyc = 1'b0;
      if (to_d) d_respack = 1'b1; else i_respack = 1'b1;
      @(negedge clk);
      d_respack = 1'b0; i_respack = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({m_reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc, m_respack} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {m_reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc, m_respack});
      end
      vectors++;
      if (m_req !== '0 || m_reqtag !== '0 || m_reqdata !== '0) begin
         miscompares++;
         $display("FAIL reset_mreq: got req %0h tag %0h required 0", m_req, m_reqtag);
      end
      vectors++;
      if (i_resp !== '0 || d_resp !== '0 || i_resptag !== '0 || d_resptag !== '0) begin
         miscompares++;
         $display("FAIL reset_resp: got itag %0h dtag %0h required 0", i_resptag, d_resptag);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         vectors++;
         if (i_reqack !== 1'b0 || d_reqack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_ack: cycle %0d got i=%b d=%b required 0 0", k, i_reqack, d_reqack);
         end
      end
   endtask

   task automatic test_round_robin();
      logic exp_d;
      apply_reset();
      i_req = 64'h0000_0100; i_reqtag = 13'h0011;
      d_req = 64'h0000_0200; d_reqtag = 13'h0022;
      i_reqcyc = 1'b1; d_reqcyc = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_d = (k % 2 == 0);
         @(negedge clk);
         vectors++;
         if (d_reqack !== exp_d || i_reqack !== !exp_d || m_reqtag !== (exp_d ? 13'h0022 : 13'h0011)) begin
            miscompares++;
            $display("FAIL rr_grant%0d: got dack=%b iack=%b tag=%0h required dack=%b iack=%b",
                     k, d_reqack, i_reqack, m_reqtag, exp_d, !exp_d);
         end
         if (k == 3) begin
            i_reqcyc = 1'b0; d_reqcyc = 1'b0;
         end
         finish_txn(exp_d);
      end
   endtask

   task automatic test_single_write();
      logic [DW-1:0] wdat;
      logic [DW-1:0] rdat;
      wdat = {16{32'ha5a5_0001}};
      rdat = {16{32'h5a5a_0002}};
      d_req = 64'h1000; d_reqtag = 13'h1007; d_reqdata = wdat; d_reqcyc = 1'b1;
      @(negedge clk);
      d_reqcyc = 1'b0;
      vectors++;
      if (d_reqack !== 1'b1 || i_reqack !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_ack: got d=%b i=%b required 1 0", d_reqack, i_reqack);
      end
      vectors++;
      if (m_reqcyc !== 1'b1 || m_req !== 64'h1000 || m_reqtag !== 13'h1007 || m_reqdata !== wdat) begin
         miscompares++;
         $display("FAIL wr_mreq: got cyc=%b req=%0h tag=%0h required 1 1000 1007", m_reqcyc, m_req, m_reqtag);
      end
      @(negedge clk);
      vectors++;
      if (d_reqack !== 1'b0 || m_reqcyc !== 1'b1 || m_req !== 64'h1000 || m_reqtag !== 13'h1007) begin
         miscompares++;
         $display("FAIL wr_hold: got ack=%b cyc=%b req=%0h tag=%0h required 0 1 1000 1007",
                  d_reqack, m_reqcyc, m_req, m_reqtag);
      end
      m_reqack = 1'b1;
      @(negedge clk);
      m_reqack = 1'b0;
      vectors++;
      if (m_reqcyc !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_cyc_drop: got %b required 0", m_reqcyc);
      end
      m_resp = rdat; m_resptag = 13'h1007; m_respcyc = 1'b1;
      #1;
      vectors++;
      if (m_respack !== 1'b1) begin
         miscompares++;
         $display("FAIL wr_respack: got %b required 1", m_respack);
      end
      @(negedge clk);
      m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
      vectors++;
      if (d_respcyc !== 1'b1 || d_resptag !== 13'h1007 || d_resp !== rdat) begin
         miscompares++;
         $display("FAIL wr_dresp: got cyc=%b tag=%0h required 1 1007", d_respcyc, d_resptag);
      end
      vectors++;
      if (i_respcyc !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_iresp: got %b required 0", i_respcyc);
      end
      d_respack = 1'b1;
      @(negedge clk);
      d_respack = 1'b0;
      vectors++;
      if (d_respcyc !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_resp_done: got %b required 0", d_respcyc);
      end
   endtask

   task automatic test_mem_stall();
      logic [DW-1:0] sdat;
      sdat = {16{32'hc0de_0033}};
      d_req = 64'h2000; d_reqtag = 13'h0033; d_reqdata = sdat; d_reqcyc = 1'b1;
      @(negedge clk);
      d_reqcyc = 1'b0;
      vectors++;
      if (d_reqack !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_ack: got %b required 1", d_reqack);
      end
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (m_reqcyc !== 1'b1 || m_req !== 64'h2000 || m_reqtag !== 13'h0033 || m_reqdata !== sdat) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got cyc=%b req=%0h tag=%0h required 1 2000 33",
                     k, m_reqcyc, m_req, m_reqtag);
         end
         @(negedge clk);
      end
      m_reqack = 1'b1;
      @(negedge clk);
      m_reqack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (m_reqcyc !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_no_reissue%0d: got %b required 0", k, m_reqcyc);
         end
         @(negedge clk);
      end
      m_respcyc = 1'b1;
      @(negedge clk);
      m_respcyc = 1'b0; d_respack = 1'b1;
      @(negedge clk);
      d_respack = 1'b0;
   endtask

   task automatic test_respack_hold();
      logic [DW-1:0] rdat;
      rdat = {16{32'hfeed_0044}};
      d_req = 64'h3000; d_reqtag = 13'h0044; d_reqcyc = 1'b1;
      @(negedge clk);
      d_reqcyc = 1'b0;
      vectors++;
      if (d_reqack !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_ack: got %b required 1", d_reqack);
      end
      i_req = 64'h4000; i_reqtag = 13'h0055; i_reqcyc = 1'b1;
      m_reqack = 1'b1;
      @(negedge clk);
      m_reqack = 1'b0;
      m_resp = rdat; m_resptag = 13'h0044; m_respcyc = 1'b1;
      @(negedge clk);
      m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (d_respcyc !== 1'b1 || d_resp !== rdat || d_resptag !== 13'h0044 || i_reqack !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_deliver%0d: got cyc=%b tag=%0h iack=%b required 1 44 0",
                     k, d_respcyc, d_resptag, i_reqack);
         end
         @(negedge clk);
      end
      d_respack = 1'b1;
      @(negedge clk);
      d_respack = 1'b0;
      vectors++;
      if (d_respcyc !== 1'b0 || i_reqack !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_idle_gap: got cyc=%b iack=%b required 0 0", d_respcyc, i_reqack);
      end
      @(negedge clk);
      i_reqcyc = 1'b0;
      vectors++;
      if (i_reqack !== 1'b1 || m_reqtag !== 13'h0055 || m_req !== 64'h4000) begin
         miscompares++;
         $display("FAIL hold_next_grant: got iack=%b tag=%0h required 1 55", i_reqack, m_reqtag);
      end
      finish_txn(1'b0);
   endtask

   task automatic test_reset_in_wait();
      d_req = 64'h5000; d_reqtag = 13'h1066; d_reqcyc = 1'b1;
      @(negedge clk);
      d_reqcyc = 1'b0; m_reqack = 1'b1;
      @(negedge clk);
      m_reqack = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_resp = {16{32'hdead_beef}}; m_resptag = 13'h1066; m_respcyc = 1'b1;
      #1;
      vectors++;
      if (m_respack !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_wait_respack: got %b required 0", m_respack);
      end
      @(negedge clk);
      m_respcyc = 1'b0;
      vectors++;
      if (d_respcyc !== 1'b0 || i_respcyc !== 1'b0 || m_reqcyc !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_wait_quiet: got d=%b i=%b mcyc=%b required 0 0 0", d_respcyc, i_respcyc, m_reqcyc);
      end
      i_req = 64'h6000; i_reqtag = 13'h0077; i_reqcyc = 1'b1;
      @(negedge clk);
      i_reqcyc = 1'b0;
      vectors++;
      if (i_reqack !== 1'b1 || d_reqack !== 1'b0 || m_reqtag !== 13'h0077 || m_req !== 64'h6000) begin
         miscompares++;
         $display("FAIL rst_wait_regrant: got iack=%b dack=%b tag=%0h required 1 0 77", i_reqack, d_reqack, m_reqtag);
      end
      finish_txn(1'b0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      i_req = '0; i_reqtag = '0; i_reqdata = '0; i_reqcyc = 1'b0; i_respack = 1'b0;
      d_req = '0; d_reqtag = '0; d_reqdata = '0; d_reqcyc = 1'b0; d_respack = 1'b0;
      m_reqack = 1'b0; m_resp = '0; m_resptag = '0; m_respcyc = 1'b0;
      test_reset();
      test_round_robin();
      test_single_write();
      test_mem_stall();
      test_respack_hold();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
